// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for the VGA path.
// It keeps free-running h/v counters that advance on pixel_strobe. On each strobe it
// registers the decoded sync, active, scaled x/y and event pulses. The pixel-scale
// shift is latched only at frame wrap, so one frame never mixes two scales.
module vga_timing_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   H_W      = 10,
   parameter int   V_W      = 10
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           pixel_strobe,
   input  logic [1:0]     scale,
   output logic           hsync,
   output logic           vsync,
   output logic           active,
   output logic [H_W-1:0] x,
   output logic [V_W-1:0] y,
   output logic           frame_start,
   output logic           line_end,
   output logic           vblank_start,
   output logic [15:0]    frame_count
);

   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

   logic [H_W-1:0] h;
   logic [V_W-1:0] v;
   logic [1:0]     scale_q;

   logic [31:0] hn;
   logic [31:0] vn;
   logic        h_last;
   logic        v_last;
   logic        h_vis;
   logic        v_vis;
   logic        h_sync_on;
   logic        v_sync_on;

   // Decode the current counter position; compared at 32 bits so that sync end
   // bounds equal to the total never overflow the counter width.
   always_comb begin
      hn        = 32'(h);
      vn        = 32'(v);
      h_last    = (hn == H_TOTAL - 1);
      v_last    = (vn == V_TOTAL - 1);
      h_vis     = (hn < H_ACTIVE);
      v_vis     = (vn < V_ACTIVE);
      h_sync_on = (hn >= HS_START) && (hn < HS_END);
      v_sync_on = (vn >= VS_START) && (vn < VS_END);
   end

   // Counters, frame bookkeeping and registered outputs; pulses self-clear every clock.
   always_ff @(posedge clk) begin
      if (reset) begin
         h            <= '0;
         v            <= '0;
         frame_count  <= '0;
         scale_q      <= scale;
         hsync        <= ~HS_POL;
         vsync        <= ~VS_POL;
         active       <= 1'b0;
         x            <= '0;
         y            <= '0;
         frame_start  <= 1'b0;
         line_end     <= 1'b0;
         vblank_start <= 1'b0;
      end else begin
         frame_start  <= 1'b0;
         line_end     <= 1'b0;
         vblank_start <= 1'b0;
         if (pixel_strobe) begin
            hsync        <= h_sync_on ? HS_POL : ~HS_POL;
            vsync        <= v_sync_on ? VS_POL : ~VS_POL;
            active       <= h_vis && v_vis;
            x            <= h_vis ? (h >> scale_q) : '0;
            y            <= v_vis ? (v >> scale_q) : '0;
            frame_start  <= (h == '0) && (v == '0);
            line_end     <= h_last;
            vblank_start <= h_last && (vn == V_ACTIVE - 1);
            if (h_last) begin
               h <= '0;
               if (v_last) begin
                  v           <= '0;
                  frame_count <= frame_count + 16'd1;
                  scale_q     <= scale;
               end else begin
                  v <= v + V_W'(1);
               end
            end else begin
               h <= h + H_W'(1);
            end
         end
      end
   end

endmodule
